// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 execute-stage encodings.
// Holds icode, ALU and condition function codes, FSM states and cc bit positions.
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] A_ADD = 4'h0;
    localparam logic [3:0] A_SUB = 4'h1;
    localparam logic [3:0] A_AND = 4'h2;
    localparam logic [3:0] A_XOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam int ZF_BIT = 2;
    localparam int SF_BIT = 1;
    localparam int OF_BIT = 0;
    localparam logic [2:0] CC_RESET = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2,
        S_HALT = 2'd3
    } state_t;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: Y86 branch/cmov condition from the {ZF,SF,OF} condition codes.
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);
    logic zf, sf, ovf, lt;

    always_comb begin
        zf  = cc[ZF_BIT];
        sf  = cc[SF_BIT];
        ovf = cc[OF_BIT];
        lt  = sf ^ ovf;
        cnd = ifun == C_YES ? 1'b1 :
              ifun == C_LE  ? lt | zf :
              ifun == C_L   ? lt :
              ifun == C_E   ? zf :
              ifun == C_NE  ? !zf :
              ifun == C_GE  ? !lt :
              ifun == C_G   ? !lt && !zf : 1'b0;
    end
endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: Y86 execute stage with decode/consumer handshakes.
// Latches one instruction in IDLE, computes in EXEC, presents the result in DONE until acked.
module exec_ctrl
    import y86_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               d_com,
    output logic               d_ready,
    input  logic [3:0]         icode,
    input  logic [3:0]         ifun,
    input  logic signed [63:0] valA,
    input  logic signed [63:0] valB,
    input  logic signed [63:0] valC,
    output logic signed [63:0] valE,
    output logic               cnd,
    output logic [2:0]         cc,
    output logic               e_com,
    input  logic               e_ack,
    output logic               stat_hlt,
    output logic               stat_ins
);
    state_t      state, state_nx;
    logic [3:0]  icode_q, ifun_q;
    logic [63:0] a_q, b_q, c_q, op_res, val_e_nx;
    logic        op_valid, ins, ovf, cnd_raw;

    cond_eval u_cond (.cc(cc), .ifun(ifun_q), .cnd(cnd_raw));

    always_comb begin
        op_res   = ifun_q == A_ADD ? b_q + a_q :
                   ifun_q == A_SUB ? b_q - a_q :
                   ifun_q == A_AND ? b_q & a_q : b_q ^ a_q;
        ovf      = ifun_q == A_ADD ? (a_q[63] == b_q[63]) && (op_res[63] != b_q[63]) :
                   ifun_q == A_SUB ? (a_q[63] != b_q[63]) && (op_res[63] != b_q[63]) : 1'b0;
        op_valid = icode_q == I_OPQ && ifun_q <= A_XOR;
        ins      = icode_q > I_POPQ || (icode_q == I_OPQ && ifun_q > A_XOR);
        case (icode_q)
            I_RRMOVQ:          val_e_nx = a_q;
            I_IRMOVQ:          val_e_nx = c_q;
            I_RMMOVQ, I_MRMOVQ: val_e_nx = b_q + c_q;
            I_OPQ:             val_e_nx = op_valid ? op_res : '0;
            I_CALL, I_PUSHQ:   val_e_nx = b_q - 64'd8;
            I_RET, I_POPQ:     val_e_nx = b_q + 64'd8;
            default:           val_e_nx = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        d_ready  = 1'b0;
        e_com    = 1'b0;
        case (state)
            S_IDLE: begin
                d_ready = 1'b1;
                if (d_com) state_nx = S_EXEC;
            end
            S_EXEC: state_nx = S_DONE;
            S_DONE: begin
                e_com = 1'b1;
                if (e_ack) state_nx = (stat_hlt || stat_ins) ? S_HALT : S_IDLE;
            end
            S_HALT: state_nx = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            icode_q  <= '0;
            ifun_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            valE     <= '0;
            cnd      <= 1'b0;
            cc       <= CC_RESET;
            stat_hlt <= 1'b0;
            stat_ins <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && d_com) begin
                icode_q <= icode;
                ifun_q  <= ifun;
                a_q     <= valA;
                b_q     <= valB;
                c_q     <= valC;
            end
            // cnd uses cc from before this instruction; only a valid OPq writes cc
            if (state == S_EXEC) begin
                valE     <= val_e_nx;
                cnd      <= (icode_q == I_RRMOVQ || icode_q == I_JXX) && cnd_raw;
                stat_hlt <= icode_q == I_HALT;
                stat_ins <= ins;
                if (op_valid) cc <= {op_res == 64'd0, op_res[63], ovf};
            end
        end
    end
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: table-driven scoreboard bench for exec_ctrl.
// Covers ALU/cc/cond vectors, e_ack backpressure, halt/invalid and async reset.
module tb_exec_ctrl;
    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] a, b, c, e;
        logic        cnd;
        logic [2:0]  cc;
        logic        hlt, ins;
    } vec_t;

    logic        clk = 0, rst_n = 0, d_com = 0, e_ack = 0;
    logic [3:0]  icode = 0, ifun = 0;
    logic [63:0] valA = 0, valB = 0, valC = 0;
    logic        d_ready, cnd, e_com, stat_hlt, stat_ins;
    logic [63:0] valE;
    logic [2:0]  cc;
    int          checks = 0, errors = 0;
    vec_t        exp_q[$];
    vec_t        tbl[26];

    exec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .d_com(d_com), .d_ready(d_ready),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .valE(valE), .cnd(cnd), .cc(cc), .e_com(e_com), .e_ack(e_ack),
        .stat_hlt(stat_hlt), .stat_ins(stat_ins)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn,
                                input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                input logic [63:0] e, input logic cd, input logic [2:0] ccv);
        vec_t v;
        v.icode = ic; v.ifun = fn; v.a = a; v.b = b; v.c = c;
        v.e = e; v.cnd = cd; v.cc = ccv; v.hlt = 1'b0; v.ins = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input vec_t v, input int hold, input logic ack_dcom);
        vec_t x;
        int n;
        n = 0;
        while (!d_ready && n < 10) begin @(negedge clk); n++; end
        chk("d_ready before issue", 64'(d_ready), 64'd1);
        icode = v.icode; ifun = v.ifun; valA = v.a; valB = v.b; valC = v.c;
        d_com = 1;
        exp_q.push_back(v);
        @(posedge clk); #1 d_com = 0;
        @(negedge clk);
        n = 1;
        while (!e_com && n < 8) begin @(negedge clk); n++; end
        chk("latency", 64'(n), 64'd2);
        x = exp_q.pop_front();
        chk("valE", valE, x.e);
        chk("cnd", 64'(cnd), 64'(x.cnd));
        chk("cc", 64'(cc), 64'(x.cc));
        chk("stat_hlt", 64'(stat_hlt), 64'(x.hlt));
        chk("stat_ins", 64'(stat_ins), 64'(x.ins));
        for (int i = 0; i < hold; i++) begin
            d_com = 1; valA = 64'h77; icode = 4'h2;
            @(negedge clk);
            chk("hold e_com", 64'(e_com), 64'd1);
            chk("hold valE", valE, x.e);
            chk("hold d_ready", 64'(d_ready), 64'd0);
        end
        d_com = ack_dcom; e_ack = 1;
        @(posedge clk); #1 e_ack = 0; d_com = 0;
    endtask

    task automatic do_reset;
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk);
    endtask

    task automatic halted_check(input string name);
        for (int i = 0; i < 3; i++) begin
            d_com = 1;
            @(negedge clk);
            chk({name, " d_ready"}, 64'(d_ready), 64'd0);
            chk({name, " e_com"}, 64'(e_com), 64'd0);
        end
        d_com = 0;
    endtask

    initial begin
        vec_t v;
        tbl[0]  = mk(4'h6, 4'h0, 64'd1, 64'd7, 0, 64'd8, 0, 3'b000);
        tbl[1]  = mk(4'h6, 4'h0, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 0,
                     64'h7FFF_FFFF_FFFF_FFFF, 0, 3'b001);
        tbl[2]  = mk(4'h7, 4'h2, 0, 0, 0, 0, 1, 3'b001);
        tbl[3]  = mk(4'h2, 4'h2, 64'h1234, 0, 0, 64'h1234, 1, 3'b001);
        tbl[4]  = mk(4'h7, 4'h6, 0, 0, 0, 0, 0, 3'b001);
        tbl[5]  = mk(4'h6, 4'h1, 64'd5, 64'd5, 0, 0, 0, 3'b100);
        tbl[6]  = mk(4'h7, 4'h3, 0, 0, 0, 0, 1, 3'b100);
        tbl[7]  = mk(4'h7, 4'h4, 0, 0, 0, 0, 0, 3'b100);
        tbl[8]  = mk(4'h7, 4'h1, 0, 0, 0, 0, 1, 3'b100);
        tbl[9]  = mk(4'h7, 4'h7, 0, 0, 0, 0, 0, 3'b100);
        tbl[10] = mk(4'h2, 4'h0, 64'hDEAD, 0, 0, 64'hDEAD, 1, 3'b100);
        tbl[11] = mk(4'h3, 4'h0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 0, 3'b100);
        tbl[12] = mk(4'h4, 4'h0, 0, 64'd100, 64'd20, 64'd120, 0, 3'b100);
        tbl[13] = mk(4'h5, 4'h0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 3'b100);
        tbl[14] = mk(4'h8, 4'h0, 0, 64'h10, 0, 64'h8, 0, 3'b100);
        tbl[15] = mk(4'h9, 4'h0, 0, 64'h10, 0, 64'h18, 0, 3'b100);
        tbl[16] = mk(4'hA, 4'h0, 0, 64'h100, 0, 64'hF8, 0, 3'b100);
        tbl[17] = mk(4'hB, 4'h0, 0, 64'h100, 0, 64'h108, 0, 3'b100);
        tbl[18] = mk(4'h6, 4'h2, 64'hF0F0, 64'hFF00, 0, 64'hF000, 0, 3'b000);
        tbl[19] = mk(4'h6, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3'b010);
        tbl[20] = mk(4'h7, 4'h5, 0, 0, 0, 0, 0, 3'b010);
        tbl[21] = mk(4'h7, 4'h2, 0, 0, 0, 0, 1, 3'b010);
        tbl[22] = mk(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 3'b001);
        tbl[23] = mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 3'b001);
        tbl[24] = mk(4'h7, 4'h0, 0, 0, 0, 0, 1, 3'b001);
        tbl[25] = mk(4'h2, 4'h7, 64'h55, 0, 0, 64'h55, 0, 3'b001);

        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("reset valE", valE, 64'd0);
        chk("reset cnd", 64'(cnd), 64'd0);
        chk("reset cc", 64'(cc), 64'd4);
        chk("reset e_com", 64'(e_com), 64'd0);
        chk("reset stat", 64'({stat_hlt, stat_ins}), 64'd0);
        chk("reset d_ready", 64'(d_ready), 64'd1);

        for (int i = 0; i < 26; i++) issue(tbl[i], 0, 1'b0);

        // backpressure: result held for 5 cycles, d_com ignored incl. alongside e_ack
        issue(mk(4'hA, 4'h0, 0, 64'h100, 0, 64'hF8, 0, 3'b001), 5, 1'b1);
        chk("post-ack d_ready", 64'(d_ready), 64'd1);
        chk("post-ack e_com", 64'(e_com), 64'd0);
        @(negedge clk);
        chk("ack d_com ignored", 64'(d_ready), 64'd1);

        // async reset mid-EXEC
        issue(mk(4'h6, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3'b010), 0, 1'b0);
        icode = 4'h6; ifun = 4'h0; valA = 64'd1; valB = 64'd2; d_com = 1;
        @(posedge clk); #1 d_com = 0;
        #1 rst_n = 0;
        #1;
        chk("async valE", valE, 64'd0);
        chk("async cc", 64'(cc), 64'd4);
        chk("async cnd", 64'(cnd), 64'd0);
        chk("async e_com", 64'(e_com), 64'd0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        chk("release d_ready", 64'(d_ready), 64'd1);
        @(negedge clk);
        chk("discarded e_com", 64'(e_com), 64'd0);
        chk("discarded valE", valE, 64'd0);

        v = mk(4'h0, 4'h0, 64'd3, 64'd4, 64'd5, 0, 0, 3'b100);
        v.hlt = 1'b1;
        issue(v, 0, 1'b0);
        halted_check("halt");
        chk("halt stat_hlt held", 64'(stat_hlt), 64'd1);

        do_reset();
        chk("reset clears hlt", 64'(stat_hlt), 64'd0);
        chk("reset d_ready", 64'(d_ready), 64'd1);
        issue(mk(4'h6, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3'b010), 0, 1'b0);
        v = mk(4'hF, 4'h0, 64'd1, 64'd1, 64'd1, 0, 0, 3'b010);
        v.ins = 1'b1;
        issue(v, 0, 1'b0);
        halted_check("ins F");

        do_reset();
        issue(mk(4'h6, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3'b010), 0, 1'b0);
        v = mk(4'h6, 4'h4, 64'd3, 64'd5, 0, 0, 0, 3'b010);
        v.ins = 1'b1;
        issue(v, 0, 1'b0);
        halted_check("ins opq");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "timeout");
    end
endmodule
